// File: rtl/aemb2_gpio_pkg.sv
// Shared constants, register-file payload and read mux for the aeMB2 GPIO block.
package aemb2_gpio_pkg;

    localparam int unsigned GPIO_W = 8;
    localparam int unsigned ADR_W  = 3;
    localparam int unsigned DAT_W  = 32;
    localparam int unsigned SEL_W  = 4;

    localparam logic [ADR_W-1:0] GPIO_OUT  = 3'd0;
    localparam logic [ADR_W-1:0] GPIO_DIR  = 3'd1;
    localparam logic [ADR_W-1:0] GPIO_IN   = 3'd2;
    localparam logic [ADR_W-1:0] GPIO_STAT = 3'd3;
    localparam logic [ADR_W-1:0] GPIO_MASK = 3'd4;

    typedef struct packed {
        logic [GPIO_W-1:0] mask;
        logic [GPIO_W-1:0] stat;
        logic [GPIO_W-1:0] dir;
        logic [GPIO_W-1:0] out;
    } gpio_regs_t;

    // Read-back value for a word index; unmapped indices read as zero.
    function automatic logic [DAT_W-1:0] gpio_read_mux(
        input logic [ADR_W-1:0]  adr,
        input gpio_regs_t        regs,
        input logic [GPIO_W-1:0] pad_in
    );
        logic [GPIO_W-1:0] val;
        case (adr)
            GPIO_OUT:  val = regs.out;
            GPIO_DIR:  val = regs.dir;
            GPIO_IN:   val = pad_in;
            GPIO_STAT: val = regs.stat;
            GPIO_MASK: val = regs.mask;
            default:   val = '0;
        endcase
        return DAT_W'(val);
    endfunction

endpackage

// File: rtl/aemb2_gpio_if.sv
// Single-beat classic Wishbone slave port as seen from the arbiter's I/O bus.
interface aemb2_gpio_if;
    import aemb2_gpio_pkg::*;

    logic [ADR_W-1:0] gwb_adr_o;
    logic [DAT_W-1:0] gwb_dat_o;
    logic [SEL_W-1:0] gwb_sel_o;
    logic             gwb_stb_o;
    logic             gwb_cyc_o;
    logic             gwb_wre_o;
    logic             gwb_tag_o;
    logic [DAT_W-1:0] gwb_dat_i;
    logic             gwb_ack_i;

    modport master (
        output gwb_adr_o, gwb_dat_o, gwb_sel_o, gwb_stb_o, gwb_cyc_o, gwb_wre_o, gwb_tag_o,
        input  gwb_dat_i, gwb_ack_i
    );

    modport slave (
        input  gwb_adr_o, gwb_dat_o, gwb_sel_o, gwb_stb_o, gwb_cyc_o, gwb_wre_o, gwb_tag_o,
        output gwb_dat_i, gwb_ack_i
    );

endinterface

// File: rtl/aemb2_gpio_sync.sv
// Pad input synchroniser with history flop and post-reset arming of the rising-edge detector.
module aemb2_gpio_sync
    import aemb2_gpio_pkg::*;
#(
    parameter int unsigned SYNC = 2
) (
    input  logic              sys_clk_i,
    input  logic              sys_rst_i,
    input  logic [GPIO_W-1:0] pad,
    output logic [GPIO_W-1:0] sync,
    output logic [GPIO_W-1:0] rise
);

    localparam int unsigned ARM_MAX = SYNC + 1;
    localparam int unsigned CNT_W   = (ARM_MAX < 4) ? 2 : $clog2(ARM_MAX + 1);

    logic [GPIO_W-1:0] chain [SYNC];
    logic [GPIO_W-1:0] hist;
    logic [CNT_W-1:0]  arm_cnt;
    logic              armed;

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            for (int unsigned k = 0; k < SYNC; k++) begin
                chain[k] <= '0;
            end
            hist <= '0;
        end else begin
            chain[0] <= pad;
            for (int unsigned k = 1; k < SYNC; k++) begin
                chain[k] <= chain[k-1];
            end
            hist <= chain[SYNC-1];
        end
    end

    // Edges stay suppressed until the chain and history hold real pad state.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            arm_cnt <= '0;
        end else if (arm_cnt != CNT_W'(ARM_MAX)) begin
            arm_cnt <= arm_cnt + CNT_W'(1);
        end
    end

    assign armed = (arm_cnt == CNT_W'(ARM_MAX));
    assign sync  = chain[SYNC-1];
    assign rise  = sync & ~hist & {GPIO_W{armed}};

endmodule

// File: rtl/aemb2_gpio.sv
// aeMB2 8-bit GPIO: Wishbone register file, tristate pads and masked rising-edge interrupt.
module aemb2_gpio
    import aemb2_gpio_pkg::*;
#(
    parameter int unsigned SYNC = 2
) (
    input  logic              sys_clk_i,
    input  logic              sys_rst_i,
    aemb2_gpio_if.slave       gwb,
    inout  wire  [GPIO_W-1:0] gpio,
    output logic [GPIO_W-1:0] leds,
    output logic              irq_o
);

    gpio_regs_t        regs;
    logic              req_c;
    logic              wr_c;
    logic              rd_c;
    logic [GPIO_W-1:0] stat_clr_c;
    logic [GPIO_W-1:0] pad_sync;
    logic [GPIO_W-1:0] pad_rise;
    logic              unused_bus_bits;

    aemb2_gpio_sync #(
        .SYNC (SYNC)
    ) u_sync (
        .sys_clk_i (sys_clk_i),
        .sys_rst_i (sys_rst_i),
        .pad       (gpio),
        .sync      (pad_sync),
        .rise      (pad_rise)
    );

    assign req_c = gwb.gwb_stb_o & gwb.gwb_cyc_o & ~gwb.gwb_ack_i;
    assign wr_c  = req_c & gwb.gwb_wre_o & gwb.gwb_sel_o[0];
    assign rd_c  = req_c & ~gwb.gwb_wre_o;

    always_comb begin
        stat_clr_c = '0;
        if (wr_c && (gwb.gwb_adr_o == GPIO_STAT)) begin
            stat_clr_c = gwb.gwb_dat_o[GPIO_W-1:0];
        end
    end

    // Register file and bus response; a same-cycle rise beats a W1C clear.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            regs          <= '0;
            gwb.gwb_ack_i <= 1'b0;
            gwb.gwb_dat_i <= '0;
            irq_o         <= 1'b0;
        end else begin
            gwb.gwb_ack_i <= req_c;
            if (rd_c) begin
                gwb.gwb_dat_i <= gpio_read_mux(gwb.gwb_adr_o, regs, pad_sync);
            end
            if (wr_c) begin
                case (gwb.gwb_adr_o)
                    GPIO_OUT:  regs.out  <= gwb.gwb_dat_o[GPIO_W-1:0];
                    GPIO_DIR:  regs.dir  <= gwb.gwb_dat_o[GPIO_W-1:0];
                    GPIO_MASK: regs.mask <= gwb.gwb_dat_o[GPIO_W-1:0];
                    default: ;
                endcase
            end
            regs.stat <= (regs.stat & ~stat_clr_c) | pad_rise;
            irq_o     <= |(regs.stat & regs.mask);
        end
    end

    for (genvar i = 0; i < GPIO_W; i++) begin : g_pad
        assign gpio[i] = regs.dir[i] ? regs.out[i] : 1'bz;
    end

    assign leds = regs.out;

    assign unused_bus_bits = ^{gwb.gwb_dat_o[DAT_W-1:GPIO_W], gwb.gwb_sel_o[SEL_W-1:1], gwb.gwb_tag_o};

endmodule
